// File: rtl/biss_pkg.sv
// biss_pkg: shared definitions for the BiSS-C slave transmitter.
//   state_e     - frame sequencer states
//   CRC_W       - CRC register width
//   CRC_POLY    - CRC6 polynomial x^6+x+1 without the implicit x^6 term
//   clamp_bits  - maps a requested position length onto 1..bits_max
package biss_pkg;

  localparam int              CRC_W    = 6;
  localparam logic [CRC_W-1:0] CRC_POLY = 6'h03;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACK,
    S_START,
    S_CDS,
    S_DATA,
    S_NE,
    S_NW,
    S_CRC,
    S_TIMEOUT
  } state_e;

  // A zero length would leave nothing to shift, so it is promoted to one bit;
  // anything wider than the position register is cut to the register width.
  function automatic logic [7:0] clamp_bits(input logic [7:0] bits,
                                            input logic [7:0] bits_max);
    if (bits == 8'd0) return 8'd1;
    if (bits > bits_max) return bits_max;
    return bits;
  endfunction

endpackage

// File: rtl/biss_crc6.sv
// biss_crc6: serial CRC6 (x^6+x+1, init 0) over the bits put on SLO.
//   clk_i     system clock
//   reset_n_i asynchronous active-low reset
//   clr_i     synchronous clear (frame start)
//   en_i      shift one bit in this cycle
//   bit_i     bit being shifted in
//   crc_o     current CRC register (transmitted inverted by the caller)
module biss_crc6
  import biss_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic fb;

  assign fb = crc_o[CRC_W-1] ^ bit_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      crc_o <= '0;
    end else if (clr_i) begin
      crc_o <= '0;
    end else if (en_i) begin
      crc_o <= {crc_o[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/biss_slave_tx.sv
// biss_slave_tx: BiSS-C encoder-side transmitter.
// Answers each MA falling edge with the next SLO bit of the frame
// ACK.., START, CDS(0), position MSB first, nE, nW, ~CRC6, then holds SLO low
// until MA has been idle high for TIMEOUT_CYCLES clocks.
//   clk_i        system clock
//   reset_n_i    asynchronous active-low reset
//   biss_sck_i   MA clock from the master (asynchronous, idle high)
//   BITS         position length; latched at frame start
//   position_i   right-aligned position word; latched at frame start
//   nerror_i     nE flag (active low); latched at frame start
//   nwarn_i      nW flag (active low); latched at frame start
//   biss_dat_o   SLO line to the master (registered)
//   busy_o       high from frame start until back in IDLE
//   frame_done_o one-cycle pulse when the timeout expires
module biss_slave_tx
  import biss_pkg::*;
#(
  parameter int BITS_MAX       = 32,
  parameter int ACK_CLKS       = 1,
  parameter int TIMEOUT_CYCLES = 2500
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                biss_sck_i,
  input  logic [7:0]          BITS,
  input  logic [BITS_MAX-1:0] position_i,
  input  logic                nerror_i,
  input  logic                nwarn_i,
  output logic                biss_dat_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int CNT_W      = (BITS_MAX > 1) ? $clog2(BITS_MAX) : 1;
  localparam int ACK_W      = 4;
  localparam int CRC_CNT_W  = $clog2(CRC_W);
  localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);

  // MA synchroniser and edge detection
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic ma_fall, ma_rise;

  // Frame state
  state_e                 state_q, state_d;
  logic                   dat_q, dat_d;
  logic                   done_q, done_d;
  logic [ACK_W-1:0]       ack_cnt_q, ack_cnt_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [CRC_CNT_W-1:0]   crc_cnt_q, crc_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]       bits_m1_q, bits_m1_d;
  logic [BITS_MAX-1:0]    pos_q, pos_d;
  logic                   ne_q, ne_d;
  logic                   nw_q, nw_d;

  // CRC interface
  logic                   crc_clr, crc_en, crc_bit;
  logic [CRC_W-1:0]       crc;

  logic [7:0]             bits_clamped;
  logic [CNT_W-1:0]       bit_cnt_dec;
  logic [CRC_CNT_W-1:0]   crc_cnt_dec;

  assign bits_clamped = clamp_bits(BITS, 8'(BITS_MAX));
  assign bit_cnt_dec  = bit_cnt_q - CNT_W'(1);
  assign crc_cnt_dec  = crc_cnt_q - CRC_CNT_W'(1);

  // Synchroniser idles high like MA itself, so leaving reset with MA high
  // never looks like a falling edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sck_meta_q <= 1'b1;
      sck_sync_q <= 1'b1;
      sck_prev_q <= 1'b1;
    end else begin
      sck_meta_q <= biss_sck_i;
      sck_sync_q <= sck_meta_q;
      sck_prev_q <= sck_sync_q;
    end
  end

  assign ma_fall = sck_prev_q & ~sck_sync_q;
  assign ma_rise = ~sck_prev_q & sck_sync_q;

  biss_crc6 u_crc (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (crc_clr),
    .en_i      (crc_en),
    .bit_i     (crc_bit),
    .crc_o     (crc)
  );

  // Next-state / next-output logic. The CRC is advanced on the same MA fall
  // that places a covered bit on SLO, so crc_bit always equals dat_d there.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave
    // a signal unassigned, which would infer a latch.
    state_d   = state_q;
    dat_d     = dat_q;
    done_d    = 1'b0;
    ack_cnt_d = ack_cnt_q;
    bit_cnt_d = bit_cnt_q;
    crc_cnt_d = crc_cnt_q;
    to_cnt_d  = to_cnt_q;
    bits_m1_d = bits_m1_q;
    pos_d     = pos_q;
    ne_d      = ne_q;
    nw_d      = nw_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_bit   = 1'b0;

    case (state_q)
      S_IDLE: begin
        dat_d = 1'b1;
        if (ma_fall) begin
          bits_m1_d = CNT_W'(bits_clamped - 8'd1);
          pos_d     = position_i;
          ne_d      = nerror_i;
          nw_d      = nwarn_i;
          crc_clr   = 1'b1;
          ack_cnt_d = ACK_W'(1);
          dat_d     = 1'b0;
          state_d   = S_ACK;
        end
      end

      S_ACK: begin
        if (ma_fall) begin
          if (ack_cnt_q == ACK_W'(ACK_CLKS)) begin
            dat_d   = 1'b1;
            state_d = S_START;
          end else begin
            ack_cnt_d = ack_cnt_q + ACK_W'(1);
          end
        end
      end

      S_START: begin
        if (ma_fall) begin
          dat_d   = 1'b0;
          state_d = S_CDS;
        end
      end

      S_CDS: begin
        if (ma_fall) begin
          dat_d     = pos_q[bits_m1_q];
          crc_en    = 1'b1;
          crc_bit   = pos_q[bits_m1_q];
          bit_cnt_d = bits_m1_q;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (ma_fall) begin
          crc_en = 1'b1;
          if (bit_cnt_q == '0) begin
            dat_d   = ne_q;
            crc_bit = ne_q;
            state_d = S_NE;
          end else begin
            bit_cnt_d = bit_cnt_dec;
            dat_d     = pos_q[bit_cnt_dec];
            crc_bit   = pos_q[bit_cnt_dec];
          end
        end
      end

      S_NE: begin
        if (ma_fall) begin
          dat_d   = nw_q;
          crc_en  = 1'b1;
          crc_bit = nw_q;
          state_d = S_NW;
        end
      end

      S_NW: begin
        if (ma_fall) begin
          dat_d     = ~crc[CRC_W-1];
          crc_cnt_d = CRC_CNT_W'(CRC_W - 1);
          state_d   = S_CRC;
        end
      end

      S_CRC: begin
        if (ma_fall) begin
          if (crc_cnt_q != '0) begin
            dat_d     = ~crc[crc_cnt_dec];
            crc_cnt_d = crc_cnt_dec;
          end else begin
            dat_d    = 1'b0;
            to_cnt_d = '0;
            state_d  = S_TIMEOUT;
          end
        end
      end

      S_TIMEOUT: begin
        // Only an uninterrupted high stretch of MA releases the line; any
        // edge (including a stray fall) restarts the count.
        dat_d = 1'b0;
        if (ma_fall || ma_rise) begin
          to_cnt_d = '0;
        end else if (sck_sync_q) begin
          if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            dat_d    = 1'b1;
            done_d   = 1'b1;
            to_cnt_d = '0;
            state_d  = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end

      default: begin
        dat_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      dat_q     <= 1'b1;
      done_q    <= 1'b0;
      ack_cnt_q <= '0;
      bit_cnt_q <= '0;
      crc_cnt_q <= '0;
      to_cnt_q  <= '0;
      bits_m1_q <= '0;
      pos_q     <= '0;
      ne_q      <= 1'b0;
      nw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dat_q     <= dat_d;
      done_q    <= done_d;
      ack_cnt_q <= ack_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      crc_cnt_q <= crc_cnt_d;
      to_cnt_q  <= to_cnt_d;
      bits_m1_q <= bits_m1_d;
      pos_q     <= pos_d;
      ne_q      <= ne_d;
      nw_q      <= nw_d;
    end
  end

  assign biss_dat_o   = dat_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_biss_slave_tx.sv
// Bench for biss_slave_tx: two instances (ACK_CLKS=1 / ACK_CLKS=3) each with
// its own MA line. Expected SLO streams come from a reference model that
// builds the frame as a bit list and computes the CRC by polynomial long
// division.
module tb_biss_slave_tx;

  localparam int BITS_MAX = 32;
  localparam int HALF     = 8;     // MA half period in clk_i cycles
  localparam int TO_A     = 2500;
  localparam int TO_B     = 300;

  logic                clk_i     = 1'b0;
  logic                reset_n_i = 1'b0;
  logic                sck_a     = 1'b1;
  logic                sck_b     = 1'b1;
  logic [7:0]          bits      = 8'd8;
  logic [BITS_MAX-1:0] position  = '0;
  logic                nerror    = 1'b1;
  logic                nwarn     = 1'b1;
  logic                dat_a, busy_a, done_a;
  logic                dat_b, busy_b, done_b;

  int checks   = 0;
  int failures = 0;
  int pulses_a = 0;
  int pulses_b = 0;

  logic rx_q[$];
  logic exp_q[$];

  typedef struct {
    int                  sel;
    int                  ack;
    logic [7:0]          bits;
    logic [31:0]         pos;
    logic                ne;
    logic                nw;
    int                  exp_n;
    logic [31:0]         exp_data;
    logic [1:0]          exp_nenw;
    logic                crc_known;
    logic [5:0]          exp_crc;
  } vec_t;

  always #4 clk_i = ~clk_i;

  biss_slave_tx #(.BITS_MAX(BITS_MAX), .ACK_CLKS(1), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .biss_sck_i   (sck_a),
    .BITS         (bits),
    .position_i   (position),
    .nerror_i     (nerror),
    .nwarn_i      (nwarn),
    .biss_dat_o   (dat_a),
    .busy_o       (busy_a),
    .frame_done_o (done_a)
  );

  biss_slave_tx #(.BITS_MAX(BITS_MAX), .ACK_CLKS(3), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .biss_sck_i   (sck_b),
    .BITS         (bits),
    .position_i   (position),
    .nerror_i     (nerror),
    .nwarn_i      (nwarn),
    .biss_dat_o   (dat_b),
    .busy_o       (busy_b),
    .frame_done_o (done_b)
  );

  always @(posedge clk_i) begin
    if (done_a) pulses_a++;
    if (done_b) pulses_b++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s: got=%0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  function automatic logic cur_dat(input int sel);
    return (sel == 0) ? dat_a : dat_b;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction

  function automatic int cur_pulses(input int sel);
    return (sel == 0) ? pulses_a : pulses_b;
  endfunction

  task automatic set_sck(input int sel, input logic v);
    if (sel == 0) sck_a = v;
    else          sck_b = v;
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp_len(input int b);
    if (b == 0) return 1;
    if (b > BITS_MAX) return BITS_MAX;
    return b;
  endfunction

  // Remainder of msg(x) * x^6 modulo x^6 + x + 1 (msg[0] is the highest term).
  function automatic logic [5:0] crc_of(input logic [0:63] msg, input int len);
    logic [0:63] w;
    logic [5:0]  r;
    w = msg;
    for (int i = 0; i < len; i++) begin
      if (w[i]) begin
        w[i]   = 1'b0;
        w[i+5] = ~w[i+5];
        w[i+6] = ~w[i+6];
      end
    end
    for (int i = 0; i < 6; i++) r[5-i] = w[len+i];
    return r;
  endfunction

  // Expected SLO value seen at each MA rise, including the trailing timeout 0.
  task automatic build_expected(input int ack, input logic [7:0] b, input logic [31:0] pos,
                                input logic ne, input logic nw);
    int          n;
    logic [0:63] msg;
    logic [5:0]  crc;
    n   = clamp_len(int'(b));
    msg = '0;
    exp_q.delete();
    repeat (ack) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      msg[i] = pos[n-1-i];
      exp_q.push_back(msg[i]);
    end
    msg[n]   = ne;
    msg[n+1] = nw;
    exp_q.push_back(ne);
    exp_q.push_back(nw);
    crc = crc_of(msg, n + 2);
    for (int i = 5; i >= 0; i--) exp_q.push_back(~crc[i]);
    exp_q.push_back(1'b0);
  endtask

  // ---------------- stimulus ----------------
  task automatic run_frame(input int sel, input int ack, input logic [7:0] b,
                           input logic [31:0] pos, input logic ne, input logic nw,
                           input bit scramble);
    logic s;
    int   nf;
    int   bad;
    bits     = b;
    position = pos;
    nerror   = ne;
    nwarn    = nw;
    @(negedge clk_i);
    check("idle_dat", cur_dat(sel), 1'b1);
    check("idle_busy", cur_busy(sel), 1'b0);
    build_expected(ack, b, pos, ne, nw);
    nf = exp_q.size();
    rx_q.delete();
    for (int i = 0; i < nf; i++) begin
      set_sck(sel, 1'b0);
      repeat (HALF) @(negedge clk_i);
      s = cur_dat(sel);
      rx_q.push_back(s);
      if (i == 0) begin
        check("busy_on", cur_busy(sel), 1'b1);
        if (scramble) begin
          bits     = 8'($urandom);
          position = $urandom;
          nerror   = 1'($urandom);
          nwarn    = 1'($urandom);
        end
      end
      set_sck(sel, 1'b1);
      repeat (HALF) @(negedge clk_i);
    end
    bad = 0;
    for (int i = 0; i < nf; i++) if (rx_q[i] !== exp_q[i]) bad++;
    check("frame_bits", bad, 0);
  endtask

  // since = clk cycles already elapsed since the last MA rise.
  task automatic finish_timeout(input int sel, input int t, input int since);
    int   k;
    int   p0;
    logic seen;
    k    = since;
    seen = 1'b0;
    p0   = cur_pulses(sel);
    while (k < t + HALF + 40) begin
      if (cur_dat(sel) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
      k++;
    end
    check("release_seen", seen, 1'b1);
    check_range("timeout_len", k, t, t + 6);
    check("done_with_release", cur_done(sel), 1'b1);
    check("busy_drop", cur_busy(sel), 1'b0);
    @(negedge clk_i);
    check("done_single", cur_done(sel), 1'b0);
    repeat (4) @(negedge clk_i);
    check("done_count", cur_pulses(sel) - p0, 1);
  endtask

  initial begin
    vec_t        tbl[6];
    logic [31:0] got_data;
    logic [1:0]  got_nenw;
    logic [5:0]  got_crc;
    int          n, a, p0;

    tbl[0] = '{0, 1, 8'd8,  32'h0000_00A5, 1'b1, 1'b1, 8,  32'h0000_00A5, 2'b11, 1'b1, 6'h24};
    tbl[1] = '{0, 1, 8'd1,  32'h0000_0000, 1'b1, 1'b1, 1,  32'h0000_0000, 2'b11, 1'b1, 6'h3A};
    tbl[2] = '{0, 1, 8'd8,  32'h0000_0000, 1'b0, 1'b0, 8,  32'h0000_0000, 2'b00, 1'b1, 6'h3F};
    tbl[3] = '{0, 1, 8'd0,  32'hFFFF_FFFF, 1'b1, 1'b1, 1,  32'h0000_0001, 2'b11, 1'b1, 6'h36};
    tbl[4] = '{0, 1, 8'd40, 32'h8000_0001, 1'b1, 1'b0, 32, 32'h8000_0001, 2'b10, 1'b0, 6'h00};
    tbl[5] = '{1, 3, 8'd32, 32'hDEAD_BEEF, 1'b1, 1'b1, 32, 32'hDEAD_BEEF, 2'b11, 1'b0, 6'h00};

    repeat (4) @(negedge clk_i);
    check("rst_dat_a", dat_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_done_a", done_a, 1'b0);
    check("rst_dat_b", dat_b, 1'b1);
    reset_n_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // Table-driven frames, decoded like a master would.
    for (int v = 0; v < 6; v++) begin
      a = tbl[v].ack;
      n = tbl[v].exp_n;
      run_frame(tbl[v].sel, a, tbl[v].bits, tbl[v].pos, tbl[v].ne, tbl[v].nw, 1'b1);
      got_data = '0;
      got_crc  = '0;
      for (int i = 0; i < n; i++) got_data = {got_data[30:0], rx_q[a+2+i]};
      got_nenw = {rx_q[a+2+n], rx_q[a+3+n]};
      for (int i = 0; i < 6; i++) got_crc = {got_crc[4:0], rx_q[a+4+n+i]};
      check("hdr_start", rx_q[a], 1'b1);
      check("hdr_cds", rx_q[a+1], 1'b0);
      check("data", got_data, tbl[v].exp_data);
      check("nenw", got_nenw, tbl[v].exp_nenw);
      if (tbl[v].crc_known) check("crc", got_crc, tbl[v].exp_crc);
      finish_timeout(tbl[v].sel, (tbl[v].sel == 0) ? TO_A : TO_B, HALF);
    end

    // Randomised frames against the model.
    for (int r = 0; r < 8; r++) begin
      int sel;
      sel = (r < 6) ? 0 : 1;
      run_frame(sel, (sel == 0) ? 1 : 3, 8'($urandom_range(0, 40)), $urandom,
                1'($urandom), 1'($urandom), 1'b1);
      finish_timeout(sel, (sel == 0) ? TO_A : TO_B, HALF);
    end

    // Stray MA fall during the timeout restarts the count, starts no frame.
    run_frame(0, 1, 8'd4, 32'h0000_0009, 1'b1, 1'b1, 1'b0);
    p0 = pulses_a;
    repeat (1000 - HALF) @(negedge clk_i);
    check("to_mid_dat", dat_a, 1'b0);
    check("to_mid_busy", busy_a, 1'b1);
    sck_a = 1'b0;
    repeat (HALF) @(negedge clk_i);
    check("to_glitch_dat", dat_a, 1'b0);
    sck_a = 1'b1;
    check("to_no_early_done", pulses_a - p0, 0);
    finish_timeout(0, TO_A, 0);
    repeat (20) @(negedge clk_i);
    check("to_no_frame_busy", busy_a, 1'b0);
    check("to_no_frame_dat", dat_a, 1'b1);

    // Asynchronous reset in the middle of the data field.
    bits     = 8'd32;
    position = $urandom;
    for (int i = 0; i < 10; i++) begin
      sck_a = 1'b0;
      repeat (HALF) @(negedge clk_i);
      sck_a = 1'b1;
      repeat (HALF) @(negedge clk_i);
    end
    check("pre_rst_busy", busy_a, 1'b1);
    #1 reset_n_i = 1'b0;
    #1;
    check("mid_rst_dat", dat_a, 1'b1);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_done", done_a, 1'b0);
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    run_frame(0, 1, 8'd12, 32'h0000_0ABC, 1'b0, 1'b1, 1'b0);
    finish_timeout(0, TO_A, HALF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
